// File: rtl/nios2_div_pkg.sv
// nios2_div_pkg: shared types and constants for the Nios II M-stage divider.
// Build option: NIOS2_DIV_RADIX4_EN selects two restoring steps per cycle.
package nios2_div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient forced on a zero divisor (all ones, as the classic restoring array yields)
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Number of CALC cycles for a given width and step count per cycle
    function automatic int div_iters(input int width, input bit radix4);
        if (radix4) begin
            return width / 2;
        end else begin
            return width;
        end
    endfunction

    localparam int DIV_ITERS_RADIX2 = div_iters(DIV_WIDTH, 1'b0);
    localparam int DIV_ITERS_RADIX4 = div_iters(DIV_WIDTH, 1'b1);

endpackage

// File: rtl/nios2_div_step.sv
// nios2_div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor; the subtraction is kept only when it does not borrow.
module nios2_div_step
    import nios2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // Two guard bits: one for the shifted-in bit, one for the borrow
    logic [WIDTH+1:0] trial_s;

    // Trial subtraction and restore decision
    always_comb begin
        trial_s  = {1'b0, rem, dvd_msb} - {2'b00, divisor};
        rem_next = {rem[WIDTH-2:0], dvd_msb};
        q_bit    = 1'b0;
        if (trial_s[WIDTH+1] == 1'b0) begin
            // Partial remainder was below 2*divisor, so the difference fits WIDTH bits
            rem_next = trial_s[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            // Borrow: restore, keeping the plain shifted remainder
            rem_next = {rem[WIDTH-2:0], dvd_msb};
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/nios2_div_cell.sv
// nios2_div_cell: sequential restoring divider for div/divu.
// Fixed latency: done pulses WIDTH+2 cycles after the accepted start
// (WIDTH/2+2 when NIOS2_DIV_RADIX4_EN is defined). Operands are converted to
// magnitudes on accept, divided unsigned, then sign-corrected in FIX.
module nios2_div_cell
    import nios2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             M_div_start,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    input  logic             M_div_signed,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quotient,
    output logic [WIDTH-1:0] M_div_remainder
);

`ifdef NIOS2_DIV_RADIX4_EN
    localparam int ITERS = div_iters(WIDTH, 1'b1);
`else
    localparam int ITERS = div_iters(WIDTH, 1'b0);
`endif
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    div_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;       // partial remainder
    logic [WIDTH-1:0] dvd_r;       // dividend bits in, quotient bits out
    logic [WIDTH-1:0] dvs_r;       // divisor magnitude
    logic [WIDTH-1:0] src1_raw_r;  // raw dividend, returned on divide by zero
    logic             q_neg_r;
    logic             r_neg_r;
    logic             div0_r;

    logic [WIDTH-1:0] mag1_s;
    logic [WIDTH-1:0] mag2_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] dvd_step_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    // Operand magnitudes for the unsigned core; raw values for divu
    always_comb begin
        mag1_s = M_div_src1;
        mag2_s = M_div_src2;
        if (M_div_signed && M_div_src1[WIDTH-1]) begin
            mag1_s = ~M_div_src1 + WIDTH'(1);
        end else begin
            mag1_s = M_div_src1;
        end
        if (M_div_signed && M_div_src2[WIDTH-1]) begin
            mag2_s = ~M_div_src2 + WIDTH'(1);
        end else begin
            mag2_s = M_div_src2;
        end
    end

`ifdef NIOS2_DIV_RADIX4_EN
    logic [WIDTH-1:0] rem_mid_s;
    logic             q_hi_s;
    logic             q_lo_s;

    nios2_div_step #(.WIDTH(WIDTH)) u_step_hi (
        .rem      (rem_r),
        .dvd_msb  (dvd_r[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_next (rem_mid_s),
        .q_bit    (q_hi_s)
    );

    nios2_div_step #(.WIDTH(WIDTH)) u_step_lo (
        .rem      (rem_mid_s),
        .dvd_msb  (dvd_r[WIDTH-2]),
        .divisor  (dvs_r),
        .rem_next (rem_step_s),
        .q_bit    (q_lo_s)
    );

    // Two dividend bits consumed, two quotient bits appended per cycle
    always_comb begin
        dvd_step_s = {dvd_r[WIDTH-3:0], q_hi_s, q_lo_s};
    end
`else
    logic q_s;

    nios2_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .dvd_msb  (dvd_r[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_next (rem_step_s),
        .q_bit    (q_s)
    );

    // One dividend bit consumed, one quotient bit appended per cycle
    always_comb begin
        dvd_step_s = {dvd_r[WIDTH-2:0], q_s};
    end
`endif

    // Sign fixup, or the fixed divide-by-zero result
    always_comb begin
        q_fix_s = dvd_r;
        r_fix_s = rem_r;
        if (div0_r) begin
            q_fix_s = WIDTH'($signed(DIV0_QUOTIENT));
            r_fix_s = src1_raw_r;
        end else begin
            if (q_neg_r) begin
                q_fix_s = ~dvd_r + WIDTH'(1);
            end else begin
                q_fix_s = dvd_r;
            end
            if (r_neg_r) begin
                r_fix_s = ~rem_r + WIDTH'(1);
            end else begin
                r_fix_s = rem_r;
            end
        end
    end

    // Control FSM, datapath registers and registered handshake/results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            rem_r           <= {WIDTH{1'b0}};
            dvd_r           <= {WIDTH{1'b0}};
            dvs_r           <= {WIDTH{1'b0}};
            src1_raw_r      <= {WIDTH{1'b0}};
            q_neg_r         <= 1'b0;
            r_neg_r         <= 1'b0;
            div0_r          <= 1'b0;
            M_div_busy      <= 1'b0;
            M_div_done      <= 1'b0;
            M_div_quotient  <= {WIDTH{1'b0}};
            M_div_remainder <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (M_div_start) begin
                        rem_r      <= {WIDTH{1'b0}};
                        dvd_r      <= mag1_s;
                        dvs_r      <= mag2_s;
                        src1_raw_r <= M_div_src1;
                        q_neg_r    <= M_div_signed & (M_div_src1[WIDTH-1] ^ M_div_src2[WIDTH-1]);
                        r_neg_r    <= M_div_signed & M_div_src1[WIDTH-1];
                        div0_r     <= (M_div_src2 == {WIDTH{1'b0}});
                        cnt_r      <= {CNT_W{1'b0}};
                        M_div_busy <= 1'b1;
                        state_r    <= ST_CALC;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r <= rem_step_s;
                    dvd_r <= dvd_step_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    M_div_quotient  <= q_fix_s;
                    M_div_remainder <= r_fix_s;
                    M_div_done      <= 1'b1;
                    state_r         <= ST_DONE;
                end
                ST_DONE: begin
                    // A start seen here is dropped: the request must wait for IDLE
                    M_div_done <= 1'b0;
                    M_div_busy <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    cnt_r      <= {CNT_W{1'b0}};
                    M_div_done <= 1'b0;
                    M_div_busy <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_div_cell.sv
// tb_nios2_div_cell: randomized and directed self-checking bench for nios2_div_cell.
// Expected results come from plain 64-bit integer division in the bench.
module tb_nios2_div_cell;

    localparam int W = 32;
`ifdef NIOS2_DIV_RADIX4_EN
    localparam int LAT = W / 2 + 2;
`else
    localparam int LAT = W + 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          sgn;
    logic          busy;
    logic          done;
    logic [W-1:0]  quot;
    logic [W-1:0]  rem;

    int tests_run    = 0;
    int tests_failed = 0;

    nios2_div_cell #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .M_div_start     (start),
        .M_div_src1      (src1),
        .M_div_src2      (src2),
        .M_div_signed    (sgn),
        .M_div_busy      (busy),
        .M_div_done      (done),
        .M_div_quotient  (quot),
        .M_div_remainder (rem)
    );

    always #5 clk = ~clk;

    // Reference: integer division truncating toward zero, remainder follows dividend
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end
    endfunction

    // Issue one operation; optionally pulse start again at cycle 'poke' with other operands.
    // Returns results at the done cycle, the measured latency and the busy-low count.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int poke, output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int busy_bad,
                          output logic [31:0] hold_q, output logic [31:0] hold_r);
        @(negedge clk);
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; sgn = 1'($urandom_range(0, 1));
        lat = 1; busy_bad = 0; hold_q = quot; hold_r = rem;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_bad++;
            if (lat == 3) begin hold_q = quot; hold_r = rem; end
            if (lat == poke) begin
                start = 1'b1; src1 = 32'd1000; src2 = 32'd3; sgn = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy !== 1'b1) busy_bad++;
        q = quot;
        r = rem;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; src1 = 32'd0; src2 = 32'd0; sgn = 1'b0;
        #1;
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy, done);
        end
        tests_run++;
        if ({quot, rem} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_res: q=%h r=%h want 0 0", quot, rem);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] vb [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic        vs [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] eq [7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] er [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'h0000_1234, 32'h0000_1234, 32'd0, 32'd0};
        logic [31:0] q, r, hq, hr;
        int lat, bb;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vs[i], -1, q, r, lat, bb, hq, hr);
            tests_run++;
            if ({q, r} !== {eq[i], er[i]}) begin
                tests_failed++;
                $display("FAIL directed_%0d: q=%h r=%h want q=%h r=%h", i, q, r, eq[i], er[i]);
            end
            tests_run++;
            if (lat !== LAT || bb !== 0) begin
                tests_failed++;
                $display("FAIL directed_lat_%0d: latency=%0d busy_low=%0d want %0d 0", i, lat, bb, LAT);
            end
            @(negedge clk);
            tests_run++;
            if ({busy, done} !== 2'b00 || {quot, rem} !== {eq[i], er[i]}) begin
                tests_failed++;
                $display("FAIL directed_after_%0d: busy=%b done=%b q=%h r=%h want 0 0 held", i, busy, done, quot, rem);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er, hq, hr;
        logic s;
        int lat, bb;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 17));
                1: begin a = -32'($urandom_range(0, 100000)); b = -32'($urandom_range(1, 300)); end
                2: b = (i % 6 == 0) ? 32'd0 : b >> $urandom_range(0, 31);
                default: ;
            endcase
            model(a, b, s, eq, er);
            run_op(a, b, s, -1, q, r, lat, bb, hq, hr);
            tests_run++;
            if ({q, r} !== {eq, er} || lat !== LAT) begin
                tests_failed++;
                $display("FAIL random_%0d: %h/%h s=%b q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", i, a, b, s, q, r, lat, eq, er, LAT);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] q, r, eq, er, hq, hr, pq, pr;
        int lat, bb;
        pq = quot; pr = rem;
        model(32'hDEAD_BEEF, 32'd12345, 1'b0, eq, er);
        run_op(32'hDEAD_BEEF, 32'd12345, 1'b0, 5, q, r, lat, bb, hq, hr);
        tests_run++;
        if ({q, r} !== {eq, er} || lat !== LAT || bb !== 0) begin
            tests_failed++;
            $display("FAIL busy_ignore: q=%h r=%h lat=%0d busy_low=%0d want q=%h r=%h lat=%0d 0", q, r, lat, bb, eq, er, LAT);
        end
        tests_run++;
        if ({hq, hr} !== {pq, pr}) begin
            tests_failed++;
            $display("FAIL results_hold: q=%h r=%h want q=%h r=%h", hq, hr, pq, pr);
        end
        // Start raised in the done cycle must be dropped
        start = 1'b1; src1 = 32'd50; src2 = 32'd5; sgn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_start: busy=%b want 0", busy);
        end
        for (int i = 0; i < LAT + 4; i++) @(negedge clk);
        tests_run++;
        if ({quot, rem} !== {eq, er}) begin
            tests_failed++;
            $display("FAIL done_start_res: q=%h r=%h want q=%h r=%h", quot, rem, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r, eq, er, hq, hr;
        int lat, bb, seen;
        @(negedge clk);
        src1 = 32'd999; src2 = 32'd10; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done} !== 2'b00 || {quot, rem} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h want all 0", busy, done, quot, rem);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_nodone: active_cycles=%0d want 0", seen);
        end
        model(32'hFFFF_8000, 32'd77, 1'b1, eq, er);
        run_op(32'hFFFF_8000, 32'd77, 1'b1, -1, q, r, lat, bb, hq, hr);
        tests_run++;
        if ({q, r} !== {eq, er} || lat !== LAT) begin
            tests_failed++;
            $display("FAIL reset_mid_fresh: q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", q, r, lat, eq, er, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r, eq, er, hq, hr, a, b;
        int lat, bb;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = 32'($urandom_range(1, 1000));
            model(a, b, 1'b1, eq, er);
            // Next start lands in the IDLE cycle right after the done cycle
            run_op(a, b, 1'b1, -1, q, r, lat, bb, hq, hr);
            tests_run++;
            if ({q, r} !== {eq, er} || lat !== LAT) begin
                tests_failed++;
                $display("FAIL back_to_back_%0d: q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", i, q, r, lat, eq, er, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
